cordic_sincos: RTL and testbench



---
 rtl/cordic_sincos.sv | 73 +++++++
 tb/tb_cordic_sincos.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/cordic_sincos.sv
// cordic_sincos: iterative rotation-mode CORDIC, degrees (Q8.24) in, cos/sin (Q2.30) out.
module cordic_sincos #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] angle,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] cos_out,
  output logic [31:0] sin_out
);
  localparam logic [1:0] s_idle = 2'd0, s_run = 2'd1, s_done = 2'd2;
  localparam logic signed [39:0] gain = 40'sh009B74EDA8;
  localparam logic [39:0] atan_tab [0:63] = '{
    0: 40'h2D00000000, 1: 40'h1A90A731A6, 2: 40'h0E0947407D, 3: 40'h072001124A,
    4: 40'h03938AA64C, 5: 40'h01CA3794E5, 6: 40'h00E52A1AB2, 7: 40'h007296D7A1,
    8: 40'h00394BA51C, 9: 40'h001CA5D9B7, 10: 40'h000E52EDC1, 11: 40'h00072976FD,
    12: 40'h000394BB82, 13: 40'h0001CA5DC2, 14: 40'h0000E52EE1, 15: 40'h0000729770,
    16: 40'h0000394BB8, 17: 40'h00001CA5DC, 18: 40'h00000E52EE, 19: 40'h0000072977,
    20: 40'h00000394BC, 21: 40'h000001CA5E, 22: 40'h000000E52F, 23: 40'h0000007297,
    24: 40'h000000394C, 25: 40'h0000001CA6, 26: 40'h0000000E53, 27: 40'h0000000729,
    28: 40'h0000000395, 29: 40'h00000001CA, 30: 40'h00000000E5, 31: 40'h0000000073,
    32: 40'h0000000039, 33: 40'h000000001D, 34: 40'h000000000E, 35: 40'h0000000007,
    36: 40'h0000000004, 37: 40'h0000000002, default: 40'h0
  };
  logic [1:0] state;
  logic signed [39:0] x, y, z, xs, ys, at;
  logic [5:0] i;
  logic err_r, load, last;
  assign busy = state == s_run;
  assign done = state == s_done;
  assign load = start && state != s_run;
  // one idle iteration slot (i == ITER) registers the outputs, giving ITER+1 latency
  assign last = i == 6'(ITER);
  assign xs = x >>> i;
  assign ys = y >>> i;
  assign at = atan_tab[i];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= s_idle;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      i       <= '0;
      err_r   <= 1'b0;
      err     <= 1'b0;
      cos_out <= '0;
      sin_out <= '0;
    end else if (load) begin
      state <= s_run;
      x     <= gain;
      y     <= '0;
      z     <= {angle, 8'b0};
      i     <= '0;
      err_r <= $signed(angle) > 32'sh5A000000 || $signed(angle) < -32'sh5A000000;
    end else if (state == s_run && last) begin
      state   <= s_done;
      err     <= err_r;
      cos_out <= err_r ? '0 : x[33:2];
      sin_out <= err_r ? '0 : y[33:2];
    end else if (state == s_run) begin
      x <= z[39] ? x + ys : x - ys;
      y <= z[39] ? y - xs : y + xs;
      z <= z[39] ? z + at : z - at;
      i <= i + 6'd1;
    end else begin
      state <= s_idle;
    end
  end
endmodule

// File: tb/tb_cordic_sincos.sv
// tb_cordic_sincos: directed + random checks of cordic_sincos against a real-arithmetic sin/cos model.
module tb_cordic_sincos;
  logic clk = 0, rst_n = 1, start = 0;
  logic [31:0] angle = '0;
  logic busy, done, err;
  logic [31:0] cos_out, sin_out;
  int checks = 0, passed = 0;
  localparam real pi = 3.14159265358979323846;

  cordic_sincos #(.ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .angle(angle),
    .busy(busy), .done(done), .err(err), .cos_out(cos_out), .sin_out(sin_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp, input longint tol);
    checks++;
    assert (obs - exp <= tol && exp - obs <= tol) passed++;
    else $error("FAIL %s: observed %0d expected %0d tol %0d", tag, obs, exp, tol);
  endtask

  function automatic real deg_of(input logic [31:0] a);
    return $itor($signed(a)) / 16777216.0;
  endfunction

  task automatic run(input logic [31:0] a, output int lat);
    @(negedge clk);
    angle = a;
    start = 1;
    @(negedge clk);
    start = 0;
    angle = $urandom;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic chk_model(input string tag, input logic [31:0] a);
    real r = deg_of(a) * pi / 180.0;
    logic e = deg_of(a) > 90.0 || deg_of(a) < -90.0;
    chk({tag, ".err"}, err, e, 0);
    chk({tag, ".cos"}, $signed(cos_out), e ? 0 : longint'($cos(r) * 1073741824.0), e ? 0 : 64);
    chk({tag, ".sin"}, $signed(sin_out), e ? 0 : longint'($sin(r) * 1073741824.0), e ? 0 : 64);
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic signed [31:0] c,
                          input logic signed [31:0] s, input logic e);
    int lat;
    run(a, lat);
    chk({tag, ".lat"}, lat, 33, 0);
    chk({tag, ".busy"}, busy, 0, 0);
    chk({tag, ".err"}, err, e, 0);
    chk({tag, ".cos"}, $signed(cos_out), c, e ? 0 : 64);
    chk({tag, ".sin"}, $signed(sin_out), s, e ? 0 : 64);
  endtask

  initial begin
    int lat, ndone;
    logic exp_done;
    logic [31:0] a;
    real rec;
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 0, 0);
    chk("rst.done", done, 0, 0);
    chk("rst.err", err, 0, 0);
    chk("rst.cos", cos_out, 0, 0);
    chk("rst.sin", sin_out, 0, 0);
    rst_n = 1;

    directed("zero", 32'h00000000, 32'h40000000, 32'h0, 0);
    directed("p30", 32'h1E000000, 32'h376CF5D1, 32'h20000000, 0);
    repeat (4) @(negedge clk);
    chk("idle.done", done, 0, 0);
    chk("idle.cos", $signed(cos_out), 32'h376CF5D1, 64);
    directed("m45", 32'hD3000000, 32'h2D413CCD, 32'hD2BEC333, 0);
    directed("p90", 32'h5A000000, 32'h0, 32'h40000000, 0);
    directed("m90", 32'hA6000000, 32'h0, 32'hC0000000, 0);
    directed("p91", 32'h5B000000, 32'h0, 32'h0, 1);
    repeat (3) @(negedge clk);
    chk("errhold.err", err, 1, 0);
    directed("m91", 32'hA5000000, 32'h0, 32'h0, 1);

    // start held high: results at cycles 33, 67 and 101 with angle switched mid-run
    @(negedge clk);
    angle = 32'h0F000000;
    start = 1;
    for (int k = 0; k <= 101; k++) begin
      @(negedge clk);
      exp_done = k == 33 || k == 67 || k == 101;
      chk("hold.done", done, exp_done, 0);
      chk("hold.busy", busy, !exp_done, 0);
      if (k == 33) begin
        chk_model("hold.r1", 32'h0F000000);
        angle = 32'hE2000000;
      end
      if (k == 40) angle = 32'h14000000;
      if (k == 67) chk_model("hold.r2", 32'hE2000000);
      if (k == 99) start = 0;
      if (k == 101) chk_model("hold.r3", 32'h14000000);
    end

    @(negedge clk);
    angle = 32'h2D000000;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst.busy", busy, 0, 0);
    chk("midrst.done", done, 0, 0);
    chk("midrst.err", err, 0, 0);
    chk("midrst.cos", cos_out, 0, 0);
    chk("midrst.sin", sin_out, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst.nodone", ndone, 0, 0);
    chk("midrst.cos_after", cos_out, 0, 0);
    directed("p60", 32'h3C000000, 32'h20000000, 32'h376CF5D1, 0);

    repeat (24) begin
      a = $urandom_range(0, 32'hBE000000) - 32'h5F000000;
      run(a, lat);
      chk("rand.lat", lat, 33, 0);
      chk_model("rand", a);
    end

    for (int d = -90; d <= 90; d++) begin
      a = 32'(d * 16777216);
      run(a, lat);
      chk("sweep.lat", lat, 33, 0);
      chk("sweep.err", err, 0, 0);
      rec = $atan2($itor($signed(sin_out)), $itor($signed(cos_out))) * 180.0 / pi * 16777216.0;
      chk("sweep.angle", longint'(rec), longint'(d) * 16777216, 256);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
